// File: rtl/hazard_stall_controller.sv
// Pipeline hazard and stall sequencer: load-use stalls, taken-branch flushes,
// multi-cycle data-memory waits with timeout, and a saturating stall counter.
module hazard_stall_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             IF_ID_UsesRt,
  input  logic [4:0]       ID_EXE_Rt,
  input  logic             ID_EXE_MemRead,
  input  logic             EXE_branch_taken,
  input  logic             EXE_MEM_MemRead,
  input  logic             EXE_MEM_MemWrite,
  input  logic             mem_ready,
  input  logic             stall_clr,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             ID_EXE_write,
  output logic             EXE_MEM_write,
  output logic             IF_ID_flush,
  output logic             ID_EXE_bubble,
  output logic             MEM_WB_bubble,
  output logic             mem_error,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_MEM_WAIT = 2'b01;
  localparam logic [1:0] ST_ERROR    = 2'b10;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic              mem_error_q, mem_error_d;

  logic mem_acc, load_use;
  logic pc_w, if_id_w, id_exe_w, exe_mem_w, flush, id_bubble, wb_bubble;

  assign mem_acc  = EXE_MEM_MemRead | EXE_MEM_MemWrite;
  assign load_use = ID_EXE_MemRead && (ID_EXE_Rt != 5'd0) &&
                    ((ID_EXE_Rt == IF_ID_Rs) || (IF_ID_UsesRt && (ID_EXE_Rt == IF_ID_Rt)));

  always_comb begin
    pc_w        = 1'b1;
    if_id_w     = 1'b1;
    id_exe_w    = 1'b1;
    exe_mem_w   = 1'b1;
    flush       = 1'b0;
    id_bubble   = 1'b0;
    wb_bubble   = 1'b0;
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_error_d = mem_error_q;

    // A pending memory access freezes everything; otherwise branch beats load-use.
    if ((state_q == ST_ERROR) || (state_q == 2'b11) ||
        (state_q == ST_RUN && mem_acc && !mem_ready) ||
        (state_q == ST_MEM_WAIT && !mem_ready)) begin
      pc_w      = 1'b0;
      if_id_w   = 1'b0;
      id_exe_w  = 1'b0;
      exe_mem_w = 1'b0;
      wb_bubble = 1'b1;
    end else if (EXE_branch_taken) begin
      flush     = 1'b1;
      id_bubble = 1'b1;
    end else if (load_use) begin
      pc_w      = 1'b0;
      if_id_w   = 1'b0;
      id_bubble = 1'b1;
    end

    case (state_q)
      ST_RUN: begin
        if (mem_acc && !mem_ready) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_d = ST_RUN;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d     = ST_ERROR;
            mem_error_d = 1'b1;
          end
        end
      end
      default: begin
        state_d     = ST_ERROR;
        mem_error_d = 1'b1;
      end
    endcase
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_clr) begin
      stall_count_d = '0;
    end else if ((state_q == ST_RUN || state_q == ST_MEM_WAIT) && !pc_w &&
                 (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      stall_count_q <= '0;
      mem_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_count_q <= stall_count_d;
      mem_error_q   <= mem_error_d;
    end
  end

  // Reset must silence the pipeline controls immediately, not on the next edge.
  assign PC_write      = rst_n & pc_w;
  assign IF_ID_write   = rst_n & if_id_w;
  assign ID_EXE_write  = rst_n & id_exe_w;
  assign EXE_MEM_write = rst_n & exe_mem_w;
  assign IF_ID_flush   = rst_n & flush;
  assign ID_EXE_bubble = rst_n & id_bubble;
  assign MEM_WB_bubble = rst_n & wb_bubble;
  assign mem_error     = mem_error_q;
  assign state         = state_q;
  assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller with MEM_TIMEOUT = 4, CNT_W = 3.
module tb_hazard_stall_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] IF_ID_Rs, IF_ID_Rt, ID_EXE_Rt;
  logic       IF_ID_UsesRt, ID_EXE_MemRead, EXE_branch_taken;
  logic       EXE_MEM_MemRead, EXE_MEM_MemWrite, mem_ready, stall_clr;
  logic       PC_write, IF_ID_write, ID_EXE_write, EXE_MEM_write;
  logic       IF_ID_flush, ID_EXE_bubble, MEM_WB_bubble, mem_error;
  logic [1:0] state;
  logic [2:0] stall_count;
  logic [6:0] ctrl;

  int n_checks = 0;
  int n_fail   = 0;

  // ctrl = {PC, IF/ID, ID/EXE, EXE/MEM write, IF_ID_flush, ID_EXE_bubble, MEM_WB_bubble}
  localparam logic [6:0] C_ZERO   = 7'b0000000;
  localparam logic [6:0] C_DEF    = 7'b1111000;
  localparam logic [6:0] C_FREEZE = 7'b0000001;
  localparam logic [6:0] C_LU     = 7'b0011010;
  localparam logic [6:0] C_BR     = 7'b1111110;

  assign ctrl = {PC_write, IF_ID_write, ID_EXE_write, EXE_MEM_write,
                 IF_ID_flush, ID_EXE_bubble, MEM_WB_bubble};

  hazard_stall_controller #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_UsesRt(IF_ID_UsesRt),
    .ID_EXE_Rt(ID_EXE_Rt), .ID_EXE_MemRead(ID_EXE_MemRead),
    .EXE_branch_taken(EXE_branch_taken),
    .EXE_MEM_MemRead(EXE_MEM_MemRead), .EXE_MEM_MemWrite(EXE_MEM_MemWrite),
    .mem_ready(mem_ready), .stall_clr(stall_clr),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .ID_EXE_write(ID_EXE_write),
    .EXE_MEM_write(EXE_MEM_write), .IF_ID_flush(IF_ID_flush),
    .ID_EXE_bubble(ID_EXE_bubble), .MEM_WB_bubble(MEM_WB_bubble),
    .mem_error(mem_error), .state(state), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IF_ID_Rs = 5'd0; IF_ID_Rt = 5'd0; IF_ID_UsesRt = 1'b0;
    ID_EXE_Rt = 5'd0; ID_EXE_MemRead = 1'b0; EXE_branch_taken = 1'b0;
    EXE_MEM_MemRead = 1'b0; EXE_MEM_MemWrite = 1'b0; mem_ready = 1'b0;
    stall_clr = 1'b0;
  endtask

  task automatic clear_count();
    tick(); idle(); stall_clr = 1'b1;
    tick(); stall_clr = 1'b0; #1;
    n_checks++; if (stall_count !== 3'd0) begin n_fail++; $display("FAIL clear_count: got %0d expected 0", stall_count); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle();
    #2;
    n_checks++; if (ctrl !== C_ZERO) begin n_fail++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, C_ZERO); end
    n_checks++; if ({state, mem_error, stall_count} !== 6'd0) begin n_fail++; $display("FAIL reset_regs: got %b expected 000000", {state, mem_error, stall_count}); end
    @(negedge clk); rst_n = 1'b1; #1;
    n_checks++; if (ctrl !== C_DEF) begin n_fail++; $display("FAIL reset_release_ctrl: got %b expected %b", ctrl, C_DEF); end
  endtask

  task automatic test_load_use();
    tick(); idle(); ID_EXE_MemRead = 1'b1; ID_EXE_Rt = 5'd5; IF_ID_Rs = 5'd5; #1;
    n_checks++; if (ctrl !== C_LU) begin n_fail++; $display("FAIL load_use_ctrl: got %b expected %b", ctrl, C_LU); end
    tick(); idle(); #1;
    n_checks++; if (stall_count !== 3'd1) begin n_fail++; $display("FAIL load_use_count: got %0d expected 1", stall_count); end
    n_checks++; if (ctrl !== C_DEF) begin n_fail++; $display("FAIL load_use_cleared: got %b expected %b", ctrl, C_DEF); end
    tick(); ID_EXE_MemRead = 1'b1; ID_EXE_Rt = 5'd0; IF_ID_Rs = 5'd0; #1;
    n_checks++; if (ctrl !== C_DEF) begin n_fail++; $display("FAIL load_use_rt_zero: got %b expected %b", ctrl, C_DEF); end
    tick(); ID_EXE_Rt = 5'd7; IF_ID_Rt = 5'd7; IF_ID_Rs = 5'd3; IF_ID_UsesRt = 1'b0; #1;
    n_checks++; if (ctrl !== C_DEF) begin n_fail++; $display("FAIL load_use_rt_unused: got %b expected %b", ctrl, C_DEF); end
    IF_ID_UsesRt = 1'b1; #1;
    n_checks++; if (ctrl !== C_LU) begin n_fail++; $display("FAIL load_use_rt_used: got %b expected %b", ctrl, C_LU); end
    tick(); idle(); #1;
    n_checks++; if (stall_count !== 3'd2) begin n_fail++; $display("FAIL load_use_count2: got %0d expected 2", stall_count); end
  endtask

  task automatic test_branch();
    tick(); idle(); ID_EXE_MemRead = 1'b1; ID_EXE_Rt = 5'd5; IF_ID_Rs = 5'd5; EXE_branch_taken = 1'b1; #1;
    n_checks++; if (ctrl !== C_BR) begin n_fail++; $display("FAIL branch_over_load_use: got %b expected %b", ctrl, C_BR); end
    tick(); idle(); #1;
    n_checks++; if (stall_count !== 3'd2) begin n_fail++; $display("FAIL branch_count: got %0d expected 2", stall_count); end
  endtask

  task automatic test_mem_wait();
    clear_count();
    tick(); idle(); EXE_MEM_MemRead = 1'b1; EXE_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (ctrl !== C_FREEZE) begin n_fail++; $display("FAIL mem_wait_freeze%0d: got %b expected %b", i, ctrl, C_FREEZE); end
      n_checks++; if (state !== ((i == 0) ? 2'b00 : 2'b01)) begin n_fail++; $display("FAIL mem_wait_state%0d: got %b expected %b", i, state, (i == 0) ? 2'b00 : 2'b01); end
      tick();
    end
    mem_ready = 1'b1; #1;
    n_checks++; if (ctrl !== C_BR) begin n_fail++; $display("FAIL mem_wait_ready_cycle: got %b expected %b", ctrl, C_BR); end
    tick(); idle(); #1;
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL mem_wait_return: got %b expected 00", state); end
    n_checks++; if (stall_count !== 3'd3) begin n_fail++; $display("FAIL mem_wait_count: got %0d expected 3", stall_count); end
  endtask

  task automatic test_timeout();
    clear_count();
    tick(); idle(); EXE_MEM_MemRead = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (ctrl !== C_FREEZE) begin n_fail++; $display("FAIL timeout_freeze%0d: got %b expected %b", i, ctrl, C_FREEZE); end
      n_checks++; if (state !== ((i == 0) ? 2'b00 : 2'b01)) begin n_fail++; $display("FAIL timeout_state%0d: got %b expected %b", i, state, (i == 0) ? 2'b00 : 2'b01); end
      tick();
    end
    #1;
    n_checks++; if ({state, mem_error} !== 3'b101) begin n_fail++; $display("FAIL timeout_error: got %b expected 101", {state, mem_error}); end
    n_checks++; if (stall_count !== 3'd5) begin n_fail++; $display("FAIL timeout_count: got %0d expected 5", stall_count); end
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i != 1); #1;
      n_checks++; if ({state, mem_error, ctrl} !== {3'b101, C_FREEZE}) begin n_fail++; $display("FAIL error_sticky%0d: got %b expected %b", i, {state, mem_error, ctrl}, {3'b101, C_FREEZE}); end
      tick();
    end
    n_checks++; if (stall_count !== 3'd5) begin n_fail++; $display("FAIL error_count_held: got %0d expected 5", stall_count); end
  endtask

  task automatic test_reset_mid_wait();
    rst_n = 1'b0; #1;
    n_checks++; if ({state, mem_error, stall_count, ctrl} !== 13'd0) begin n_fail++; $display("FAIL reset_from_error: got %b expected 0", {state, mem_error, stall_count, ctrl}); end
    @(negedge clk); rst_n = 1'b1;
    tick(); idle(); EXE_MEM_MemRead = 1'b1;
    tick(); tick(); #1;
    n_checks++; if ({state, stall_count} !== 5'b01010) begin n_fail++; $display("FAIL pre_reset_wait: got %b expected 01010", {state, stall_count}); end
    #1; rst_n = 1'b0; #1;
    n_checks++; if ({state, mem_error, stall_count, ctrl} !== 13'd0) begin n_fail++; $display("FAIL reset_mid_wait: got %b expected 0", {state, mem_error, stall_count, ctrl}); end
    @(negedge clk); rst_n = 1'b1; idle(); #1;
    n_checks++; if (ctrl !== C_DEF) begin n_fail++; $display("FAIL post_reset_defaults: got %b expected %b", ctrl, C_DEF); end
    tick(); #1;
    n_checks++; if ({state, stall_count} !== 5'd0) begin n_fail++; $display("FAIL post_reset_state: got %b expected 00000", {state, stall_count}); end
  endtask

  task automatic test_saturate();
    clear_count();
    tick(); idle(); ID_EXE_MemRead = 1'b1; ID_EXE_Rt = 5'd9; IF_ID_Rs = 5'd9;
    for (int i = 1; i <= 10; i++) begin
      tick(); #1;
      n_checks++; if (stall_count !== ((i < 7) ? 3'(i) : 3'd7)) begin n_fail++; $display("FAIL saturate%0d: got %0d expected %0d", i, stall_count, (i < 7) ? i : 7); end
    end
    stall_clr = 1'b1;
    tick(); stall_clr = 1'b0; #1;
    n_checks++; if (stall_count !== 3'd0) begin n_fail++; $display("FAIL clr_over_stall: got %0d expected 0", stall_count); end
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Sequences the five-stage MIPS pipeline around the forwarding unit: it resolves the hazards forwarding cannot cover and drives the pipeline-register write enables, flushes and bubbles. It handles load-use stalls, taken-branch flushes resolved in EXE, and multi-cycle data-memory waits with a timeout. It also keeps a saturating stall-cycle counter for performance monitoring. It sits beside the forwarding unit and drives the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB registers.

## Interface
- MEM_TIMEOUT, 16: maximum cycles spent in MEM_WAIT before error; must be ≥ 2.
- CNT_W, 16: width of stall_count.

Ports (name, direction, width, meaning):
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- IF_ID_Rs, IF_ID_Rt  in  5 each  source registers of the instruction in ID.
- IF_ID_UsesRt  in  1  the ID instruction reads Rt as a source.
- ID_EXE_Rt  in  5  destination register of the instruction in EXE, when it is a load.
- ID_EXE_MemRead  in  1  the instruction in EXE is a load.
- EXE_branch_taken  in  1  a branch or jump in EXE resolved as taken.
- EXE_MEM_MemRead, EXE_MEM_MemWrite  in  1 each  the MEM stage holds a data-memory access.
- mem_ready  in  1  the data memory completes the current access this cycle.
- stall_clr  in  1  synchronous clear of stall_count.
- PC_write, IF_ID_write, ID_EXE_write, EXE_MEM_write  out  1 each  register write enables.
- IF_ID_flush  out  1  load a NOP into IF/ID.
- ID_EXE_bubble  out  1  load a bubble (all control signals zero) into ID/EXE.
- MEM_WB_bubble  out  1  load a bubble into MEM/WB.
- mem_error  out  1  sticky memory-timeout flag.
- state  out  2  state code: RUN = 00, MEM_WAIT = 01, ERROR = 10.
- stall_count  out  CNT_W  saturating count of stall cycles.

## Operation

Derived terms:
- mem_acc = EXE_MEM_MemRead | EXE_MEM_MemWrite.
- load_use = ID_EXE_MemRead & (ID_EXE_Rt != 0) & ((ID_EXE_Rt == IF_ID_Rs) | (IF_ID_UsesRt & (ID_EXE_Rt == IF_ID_Rt))).
- freeze: all four write enables are 0 and MEM_WB_bubble = 1; IF_ID_flush = 0 and ID_EXE_bubble = 0.

Default outputs: all write enables 1; flush and bubble outputs 0.

Output priority in RUN (evaluated combinationally, highest first):
1. mem_acc & !mem_ready: freeze; next state MEM_WAIT; wait_cnt is cleared to 0.
2. EXE_branch_taken: IF_ID_flush = 1, ID_EXE_bubble = 1, PC_write = 1. This overrides a simultaneous load_use.
3. load_use: PC_write = 0, IF_ID_write = 0, ID_EXE_bubble = 1.
4. Otherwise: defaults.

MEM_WAIT:
- While !mem_ready: freeze; wait_cnt increments each cycle.
  - If wait_cnt == MEM_TIMEOUT-1 and !mem_ready: next state ERROR.
- When mem_ready = 1: outputs follow RUN rules 2–4 with MEM_WB_bubble = 0; next state RUN.
- EXE is frozen, so a branch or load-use present in EXE is held and is applied in the ready cycle.

ERROR:
- freeze; mem_error = 1; remains in ERROR until rst_n is asserted.

stall_count:
- Increments on every cycle in RUN or MEM_WAIT in which PC_write == 0.
- Saturates at 2^CNT_W - 1.
- stall_clr has priority over increment and sets the count to 0 on the next edge.
- Does not count in ERROR.

## Timing
- While rst_n is low, immediately and independent of clk: state = RUN, wait_cnt = 0, stall_count = 0, mem_error = 0, and all write enables, flushes and bubbles forced to 0.
- After rst_n deasserts, the first edge sees the RUN defaults.
- Every output except mem_error, state and stall_count is combinational from the current state and inputs, with zero-cycle latency.
- A zero-wait access (mem_acc & mem_ready in RUN) causes no stall.
- An access whose mem_ready arrives k cycles after the access appears in MEM (1 ≤ k ≤ MEM_TIMEOUT) produces exactly k frozen cycles.
- With no mem_ready, RUN spends 1 frozen cycle, then MEM_WAIT spends MEM_TIMEOUT frozen cycles. ERROR is entered on the edge ending wait_cnt == MEM_TIMEOUT-1.
- A load-use stall lasts exactly one cycle: the bubble clears ID_EXE_MemRead on the next edge.
- rst_n asserted mid-MEM_WAIT or in ERROR returns immediately to the reset values.

## Test plan
- Load-use: ID_EXE_MemRead = 1, ID_EXE_Rt = 5, IF_ID_Rs = 5 → one cycle with PC_write = 0, IF_ID_write = 0, ID_EXE_bubble = 1; stall_count goes 0 → 1. Repeat with ID_EXE_Rt = 0, or with a match on Rt only while IF_ID_UsesRt = 0 → no stall.
- Branch with simultaneous load-use (EXE_branch_taken = 1, load_use true) → IF_ID_flush = 1, ID_EXE_bubble = 1, PC_write = 1, IF_ID_write = 1; stall_count unchanged.
- Memory wait: EXE_MEM_MemRead = 1 with mem_ready rising on the 4th cycle → 3 frozen cycles with MEM_WB_bubble = 1, the ready cycle advances, state returns to 00; stall_count = 3.
- Timeout with MEM_TIMEOUT = 4 and mem_ready held at 0 → 5 frozen cycles, then state = 10 and mem_error = 1; both persist while mem_ready later pulses; stall_count stops at 5.
- Reset asserted mid-MEM_WAIT → asynchronous return to state 00 with every output at its reset value; the first cycle after release shows the RUN defaults.
- Counter with CNT_W = 3 and 10 load-use stalls → stall_count saturates at 7; stall_clr together with a stall → 0 on the next edge.
